// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   W_DEFAULT   : default operand width (dividend is twice this width)
//   div_state_e : controller states
//   step_cnt_w  : width of the restoring-step counter for a given operand width
package div_pkg;

    localparam int unsigned W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Counter has to index 2W restoring steps.
    function automatic int unsigned step_cnt_w(input int unsigned w);
        return $clog2(w + w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One unsigned restoring-division step (purely combinational).
//   rem_i / rem_o : partial remainder, W+1 bits, before / after the step
//   dq_i  / dq_o  : dividend bits shifting out of the top, quotient bits
//                   shifting in at the bottom
//   dvs_i         : divisor magnitude
module div_step
    import div_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [W:0]     rem_i,
    input  logic [W+W-1:0] dq_i,
    input  logic [W-1:0]   dvs_i,
    output logic [W:0]     rem_o,
    output logic [W+W-1:0] dq_o
);

    localparam int unsigned DW = W + W;

    logic [W:0] shifted_c;
    logic [W:0] diff_c;
    logic       ge_c;

    // A set rem_i[W] means the shifted value exceeds W+1 bits and therefore
    // any divisor; the modular subtraction still yields the right remainder.
    always_comb begin
        shifted_c = {rem_i[W-1:0], dq_i[DW-1]};
        ge_c      = rem_i[W] | (shifted_c >= {1'b0, dvs_i});
        diff_c    = shifted_c - {1'b0, dvs_i};
        rem_o     = ge_c ? diff_c : shifted_c;
        dq_o      = {dq_i[DW-2:0], ge_c};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per clock, quotient truncated toward zero, remainder takes the sign of
// the dividend.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : begin a division (accepted in IDLE or DONE only)
//   dividend, divisor   : signed operands
//   quotient, remainder : signed results, valid while done is high
//   done                : result valid, held until the next accepted start
//   ovf                 : quotient does not fit in W signed bits
//   dbz                 : divisor was zero
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W+W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           done,
    output logic           ovf,
    output logic           dbz
);

    localparam int unsigned   DW        = W + W;
    localparam int unsigned   CW        = step_cnt_w(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
    // Largest quotient magnitudes representable for a positive / negative result.
    localparam logic [DW-1:0] Q_LIM_POS = DW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic [DW-1:0] Q_LIM_NEG = Q_LIM_POS + DW'(1);

    div_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [W:0]      rem_q;
    logic [DW-1:0]   dq_q;
    logic [W-1:0]    dvs_q;
    logic            qneg_q;
    logic            rneg_q;

    logic [W:0]      rem_d;
    logic [DW-1:0]   dq_d;

    logic [DW-1:0]   dvd_mag_c;
    logic [W-1:0]    dvs_mag_c;
    logic [W-1:0]    fix_quo_d;
    logic [W-1:0]    fix_rem_d;
    logic            fix_ovf_d;

    div_step #(.W(W)) u_step (
        .rem_i (rem_q),
        .dq_i  (dq_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .dq_o  (dq_d)
    );

    // Operand magnitudes; the most negative values map onto their unsigned
    // magnitude (e.g. -128 -> 8'h80), which the datapath handles directly.
    always_comb begin
        dvd_mag_c = dividend[DW-1] ? -dividend : dividend;
        dvs_mag_c = divisor[W-1]   ? -divisor  : divisor;
    end

    // Sign fix-up and range check of the unsigned results.
    always_comb begin
        fix_ovf_d = qneg_q ? (dq_q > Q_LIM_NEG) : (dq_q > Q_LIM_POS);
        fix_quo_d = qneg_q ? -dq_q[W-1:0]  : dq_q[W-1:0];
        fix_rem_d = rneg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
    end

    // Controller and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done   <= 1'b0;
                        ovf    <= 1'b0;
                        dbz    <= 1'b0;
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        dq_q   <= dvd_mag_c;
                        dvs_q  <= dvs_mag_c;
                        qneg_q <= dividend[DW-1] ^ divisor[W-1];
                        rneg_q <= dividend[DW-1];
                        if (divisor == '0) begin
                            // Divide by zero skips the iteration entirely.
                            state_q   <= ST_DONE;
                            quotient  <= '0;
                            remainder <= '0;
                            done      <= 1'b1;
                            dbz       <= 1'b1;
                        end else begin
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    dq_q  <= dq_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_DONE;
                    done    <= 1'b1;
                    ovf     <= fix_ovf_d;
                    if (fix_ovf_d) begin
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        quotient  <= fix_quo_d;
                        remainder <= fix_rem_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (W=8) against a truncating-division model.
module tb_seq_divider;

    localparam int unsigned W  = 8;
    localparam int unsigned DW = 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [W-1:0]  divisor  = '0;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          done;
    logic          ovf;
    logic          dbz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    // Reference: {quotient, remainder, ovf, dbz} from plain integer division.
    function automatic logic [17:0] ref_div(input int a, input int b);
        int q;
        int r;
        if (b == 0) return {16'h0000, 1'b0, 1'b1};
        q = a / b;
        r = a % b;
        if (q > 127 || q < -128) return {16'h0000, 1'b1, 1'b0};
        return {8'(q), 8'(r), 1'b0, 1'b0};
    endfunction

    // Issue one division; done_edge = index of the edge after which done was seen.
    task automatic run_op(input int a, input int b, output int done_edge);
        @(negedge clk);
        dividend = DW'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        done_edge = 0;
        while (!done && done_edge < 40) begin
            @(posedge clk);
            #1;
            done_edge++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout a=%0d b=%0d edges=%0d", a, b, done_edge);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, done, ovf, dbz} !== 19'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {quotient, remainder, done, ovf, dbz});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset done=%b exp=0", done);
        end
    endtask

    task automatic test_basic();
        int e;
        run_op(30, 6, e);
        checks++;
        if (e != 17) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=17", e);
        end
        checks++;
        if ({quotient, remainder, ovf, dbz} !== {8'd5, 8'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_30_6 got q=%0d r=%0d ovf=%b dbz=%b exp q=5 r=0",
                     $signed(quotient), $signed(remainder), ovf, dbz);
        end
    endtask

    task automatic test_signs();
        int ca[3] = '{-37, 37, -37};
        int cb[3] = '{5, -5, -5};
        int eq[3] = '{-7, -7, 7};
        int er[3] = '{-2, 2, -2};
        int e;
        for (int i = 0; i < 3; i++) begin
            run_op(ca[i], cb[i], e);
            checks++;
            if (quotient !== W'(eq[i]) || remainder !== W'(er[i]) || ovf !== 1'b0) begin
                failures++;
                $display("FAIL sign_%0d_%0d got q=%0d r=%0d ovf=%b exp q=%0d r=%0d", ca[i], cb[i],
                         $signed(quotient), $signed(remainder), ovf, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int e;
        run_op(5000, 3, e);
        checks++;
        if ({quotient, remainder, ovf, dbz} !== {8'd0, 8'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ovf_5000_3 got q=%h r=%h ovf=%b exp q=0 r=0 ovf=1", quotient, remainder, ovf);
        end
        run_op(256, -2, e);
        checks++;
        if ({quotient, remainder, ovf, dbz} !== {8'h80, 8'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL min_quot_256_m2 got q=%0d r=%0d ovf=%b exp q=-128 r=0 ovf=0",
                     $signed(quotient), $signed(remainder), ovf);
        end
        run_op(-32768, -1, e);
        checks++;
        if ({quotient, remainder, ovf, dbz} !== {8'd0, 8'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ovf_m32768_m1 got q=%h r=%h ovf=%b exp ovf=1", quotient, remainder, ovf);
        end
    endtask

    task automatic test_dbz();
        int e;
        run_op(10, 0, e);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL dbz_latency got=%0d exp=0", e);
        end
        checks++;
        if ({quotient, remainder, ovf, dbz} !== {8'd0, 8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL dbz_10_0 got q=%h r=%h ovf=%b dbz=%b exp dbz=1", quotient, remainder, ovf, dbz);
        end
    endtask

    task automatic test_reset_mid_op();
        int e;
        @(negedge clk);
        dividend = DW'(1234);
        divisor  = W'(5);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({quotient, remainder, done, ovf, dbz} !== 19'h0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", {quotient, remainder, done, ovf, dbz});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, done, ovf, dbz} !== 19'h0) begin
            failures++;
            $display("FAIL reset_held got=%h exp=0", {quotient, remainder, done, ovf, dbz});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_mid_reset done=%b exp=0", done);
        end
        run_op(100, 7, e);
        checks++;
        if ({quotient, remainder, ovf, dbz} !== {8'd14, 8'd2, 1'b0, 1'b0} || e != 17) begin
            failures++;
            $display("FAIL post_reset_100_7 got q=%0d r=%0d edge=%0d exp q=14 r=2 edge=17",
                     $signed(quotient), $signed(remainder), e);
        end
    endtask

    task automatic test_busy_start();
        int e;
        @(negedge clk);
        dividend = DW'(1000);
        divisor  = W'(-9);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = DW'(50);
        divisor  = W'(3);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 5;
        while (!done && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        checks++;
        if (e != 17 || quotient !== W'(-111) || remainder !== W'(1) || ovf !== 1'b0) begin
            failures++;
            $display("FAIL busy_start got q=%0d r=%0d edge=%0d exp q=-111 r=1 edge=17",
                     $signed(quotient), $signed(remainder), e);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] held;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_precondition done=%b exp=1", done);
        end
        @(negedge clk);
        dividend = DW'(-100);
        divisor  = W'(7);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_drop done=%b exp=0", done);
        end
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, ovf, dbz, done} !== {8'hF2, 8'hFE, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL b2b_m100_7 got q=%0d r=%0d done=%b exp q=-14 r=-2 done=1",
                     $signed(quotient), $signed(remainder), done);
        end
        held = ref_div(-100, 7);
        dividend = DW'(77);
        divisor  = W'(0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, ovf, dbz} !== held || done !== 1'b1) begin
            failures++;
            $display("FAIL done_stable got=%h exp=%h", {quotient, remainder, ovf, dbz}, held);
        end
    endtask

    task automatic test_sweep();
        int ca[4] = '{-128, -1, 0, 127};
        int cb[4] = '{-64, -1, 0, 63};
        int a;
        int b;
        int e;
        logic [17:0] exp_v;
        for (int n = 0; n < 516; n++) begin
            if (n < 16) begin
                a = ca[n / 4];
                b = cb[n % 4];
            end else if (n < 416) begin
                a = int'($urandom_range(255)) - 128;
                b = int'($urandom_range(127)) - 64;
            end else begin
                a = int'($urandom_range(65535)) - 32768;
                b = int'($urandom_range(255)) - 128;
            end
            exp_v = ref_div(a, b);
            run_op(a, b, e);
            checks++;
            if ({quotient, remainder, ovf, dbz} !== exp_v) begin
                failures++;
                $display("FAIL sweep %0d/%0d got=%h exp=%h", a, b, {quotient, remainder, ovf, dbz}, exp_v);
            end
            checks++;
            if (e != ((b == 0) ? 0 : 17)) begin
                failures++;
                $display("FAIL sweep_latency %0d/%0d got=%0d exp=%0d", a, b, e, (b == 0) ? 0 : 17);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_dbz();
        test_reset_mid_op();
        test_busy_start();
        test_back_to_back();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: W, 8, operand width; dividend 2W bits; divisor, quotient and remainder W bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new division, sampled on rising edge.
REQ-005 SHALL have port: dividend  input  2W  signed two's-complement dividend.
REQ-006 SHALL have port: divisor  input  W  signed two's-complement divisor.
REQ-007 SHALL have port: quotient  output  W  signed quotient, truncated toward zero.
REQ-008 SHALL have port: remainder  output  W  signed remainder, same sign as dividend (or zero).
REQ-009 SHALL have port: done  output  1  result valid; held until next accepted start or reset.
REQ-010 SHALL have port: ovf  output  1  quotient not representable in W signed bits.
REQ-011 SHALL have port: dbz  output  1  divisor was zero.

Function
REQ-012 SHALL implement states IDLE, DIV, FIX and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in DIV or FIX SHALL be ignored.
REQ-014 SHALL, on the accepting edge (edge 0), latch operands, clear done/ovf/dbz, and store magnitudes plus result sign (dividend sign XOR divisor sign) and remainder sign (dividend sign).
REQ-015 SHALL, when the latched divisor is zero, go from edge 0 directly to DONE with dbz=1, ovf=0, quotient=0, remainder=0, so done=1 one cycle after start.
REQ-016 SHALL otherwise enter DIV and perform one unsigned restoring step per cycle on edges 1..16 (2W steps), one quotient bit per step, MSB first.
REQ-017 SHALL step as follows: shift partial remainder left and take in the next dividend bit; if it is >= |divisor|, subtract and set the quotient bit to 1, else set it to 0.
REQ-018 SHALL use a partial remainder W+1 bits wide so that a divisor magnitude of 2^(W-1) does not overflow.
REQ-019 SHALL go to FIX after the 2W-th step, then on edge 2W+1 (edge 17 for W=8) register the results and enter DONE, raising done.
REQ-020 SHALL compute the results in FIX:
- negate the quotient magnitude if the result sign is negative;
- negate the remainder magnitude if the dividend sign is negative.
REQ-021 SHALL set ovf=1, quotient=0 and remainder=0 when the unsigned quotient is >2^(W-1)-1 for a positive result, or >2^(W-1) for a negative result.
REQ-022 SHALL accept a quotient of exactly -2^(W-1) (e.g. 256 / -2 = -128) without ovf.
REQ-023 SHALL handle -2^(2W-1) / -1 (e.g. -32768 / -1) as ovf=1.
REQ-024 SHALL keep all outputs stable while in DONE.
REQ-025 SHALL, when start is accepted in DONE, drop done on that same edge and begin the new operation.

Reset
REQ-026 SHALL, on reset asserted at any time including mid-operation, asynchronously force state=IDLE, step counter=0, quotient=0, remainder=0, done=0, ovf=0, dbz=0.
REQ-027 SHALL, after reset deasserts, remain in IDLE until start is sampled high.

Structure
REQ-028 SHALL place the state enum, default W and the step-count width in shared package div_pkg.
REQ-029 SHALL put the combinational compare/subtract/shift step in one sub-module, div_step, instantiated once.
REQ-030 SHALL contain no multiplier or divider operators; the only arithmetic SHALL be add, subtract and negate.

Verification
REQ-031 SHALL cover: 30 / 6 -> quotient=5, remainder=0, done at edge 17.
REQ-032 SHALL cover these sign cases:
- -37 / 5 -> quotient=-7, remainder=-2;
- 37 / -5 -> quotient=-7, remainder=2;
- -37 / -5 -> quotient=7, remainder=-2.
REQ-033 SHALL cover: 5000 / 3 -> ovf=1, quotient=0, remainder=0; and 256 / -2 -> quotient=-128, ovf=0.
REQ-034 SHALL cover: 10 / 0 -> dbz=1, done one cycle after start; and -32768 / -1 -> ovf=1.
REQ-035 SHALL cover reset at edge 8 of a division, then start 100 / 7 -> all outputs 0 during reset, then quotient=14, remainder=2.
REQ-036 SHALL cover sweep and busy-start:
- sweep dividend -128..127 against divisor -64..63, checking against the truncating reference model;
- start pulsed at edge 5 -> ignored, result unchanged.
